prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/prefetch_unit.sv | 164 ++++++++++++++++
 tb/tb_prefetch_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_unit.sv
// Instruction prefetch queue with credit-based memory requests, redirect flush and drop.
// Ports: clk, rst (async low); redirect, redirect_pc; mem_req/mem_addr/mem_rdy request
// channel; mem_rvalid/mem_rdata/mem_err response channel; inst_valid/inst_ready/inst_ifid/
// pc_ifid/err toward decode. Optional macro PF_ERR_HALT_EN: an error response halts issue.
module prefetch_unit #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PC_INC   = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rdy,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_ifid,
  output logic [ADDR_W-1:0] pc_ifid,
  output logic              err
);

`ifdef PF_ERR_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic {RUN, HALT} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] pc;
    logic              err;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     outs_q, outs_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  entry_t            q_mem [DEPTH];

  logic [CW:0] used;
  logic        credit_ok;
  logic        issue;
  logic        rsp;
  logic        push;
  logic        pop;
  entry_t      head;

  // Dropped responses stay in outs_q, so they still consume credit.
  assign used      = {1'b0, count_q} + {1'b0, outs_q};
  assign credit_ok = used < (CW+1)'(DEPTH);

  assign mem_req  = rst & ~redirect & (state_q == RUN) & credit_ok;
  assign mem_addr = fetch_pc_q;
  assign issue    = mem_req & mem_rdy;

  // Responses with nothing outstanding belong to pre-reset requests.
  assign rsp  = mem_rvalid & (outs_q != '0);
  assign push = rsp & (drop_q == '0) & ~redirect;

  assign inst_valid = (count_q != '0) & ~redirect;
  assign pop        = inst_valid & inst_ready;

  assign head      = q_mem[rd_q];
  assign inst_ifid = head.data;
  assign pc_ifid   = head.pc;
  assign err       = head.err;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    outs_d     = outs_q;
    drop_d     = drop_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    if (redirect) begin
      state_d    = RUN;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      count_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
      // A response arriving now is discarded here, not counted as a drop.
      outs_d     = outs_q - CW'(rsp);
      drop_d     = outs_q - CW'(rsp);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
      end
      outs_d = outs_q + CW'(issue) - CW'(rsp);
      if (rsp && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_d      = wr_q + PW'(1);
        resp_pc_d = resp_pc_q + ADDR_W'(PC_INC);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      unique case (state_q)
        RUN: begin
          if (HaltEn && push && mem_err) begin
            state_d = HALT;
          end
        end
        HALT: state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      fetch_pc_q <= ADDR_W'(RESET_PC);
      resp_pc_q  <= ADDR_W'(RESET_PC);
      count_q    <= '0;
      outs_q     <= '0;
      drop_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      outs_q     <= outs_d;
      drop_q     <= drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  // Storage is reset so the head outputs read zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_mem[i] <= '0;
      end
    end else if (push) begin
      q_mem[wr_q] <= '{data: mem_rdata, pc: resp_pc_q, err: mem_err};
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with a small in-order memory model.
// Covers reset, streaming, stall, redirect drop, PC wrap, error tag and reset mid-burst.
module tb_prefetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_rdy;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        mem_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_ifid;
  logic [15:0] pc_ifid;
  logic        err;

  prefetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdy    (mem_rdy),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_ifid  (inst_ifid),
    .pc_ifid    (pc_ifid),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          npass;
  int          ntot;
  int          nreq;
  logic        auto_rsp;
  logic        err_on;
  logic [15:0] err_pc;
  logic [15:0] pend [$];

  function automatic logic [15:0] dat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // One clock: log the request accepted at this edge, then present
  // the oldest pending response for the next edge.
  task automatic cyc();
    logic [15:0] a;
    #1;
    if (rst && mem_req && mem_rdy) begin
      pend.push_back(mem_addr);
      nreq++;
    end
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      if (pend.size() > 0) begin
        a = pend.pop_front();
        mem_rvalid = 1'b1;
        mem_rdata  = dat(a);
        mem_err    = err_on && (a == err_pc);
      end else begin
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    mem_rdy     = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = 16'h0;
    mem_err     = 1'b0;
    inst_ready  = 1'b0;
    auto_rsp    = 1'b0;
    err_on      = 1'b0;
    err_pc      = 16'h0;
    #1;
    pend.delete();
    nreq = 0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  logic        found;
  logic        e2;
  logic        e4;
  logic        exp_req;

  initial begin
    npass = 0;
    ntot  = 0;
    nreq  = 0;
    do_reset();
    rst = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_ifid", inst_ifid, 0);
    chk("rst_pc", pc_ifid, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", mem_addr, 0);

    // Streaming: 1-cycle memory, always ready.
    do_reset();
    mem_rdy    = 1'b1;
    inst_ready = 1'b1;
    auto_rsp   = 1'b1;
    #1;
    chk("st_req0", mem_req, 1);
    chk("st_addr0", mem_addr, 16'h0000);
    cyc();
    chk("st_v1", inst_valid, 0);
    chk("st_addr1", mem_addr, 16'h0002);
    cyc();
    chk("st_v2", inst_valid, 1);
    chk("st_pc2", pc_ifid, 16'h0000);
    chk("st_d2", inst_ifid, 16'h5A5A);
    chk("st_addr2", mem_addr, 16'h0004);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("st_vk", inst_valid, 1);
      chk("st_pck", pc_ifid, 2 * k);
      chk("st_addrk", mem_addr, 2 * k + 4);
    end

    // Stall: credit limits to DEPTH requests, head held.
    do_reset();
    mem_rdy  = 1'b1;
    auto_rsp = 1'b1;
    for (int k = 0; k < 10; k++) cyc();
    chk("stall_nreq", nreq, 4);
    chk("stall_req", mem_req, 0);
    chk("stall_valid", inst_valid, 1);
    chk("stall_pc", pc_ifid, 16'h0000);
    chk("stall_d", inst_ifid, 16'h5A5A);
    cyc();
    cyc();
    chk("stall_pc_hold", pc_ifid, 16'h0000);
    inst_ready = 1'b1;
    cyc();
    chk("stall_pop_pc", pc_ifid, 16'h0002);

    // Redirect with two responses outstanding.
    do_reset();
    mem_rdy = 1'b1;
    cyc();
    cyc();
    mem_rdy     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    #1;
    chk("rd_req_blk", mem_req, 0);
    cyc();
    redirect = 1'b0;
    mem_rdy  = 1'b1;
    auto_rsp = 1'b1;
    #1;
    chk("rd_req_resume", mem_req, 1);
    chk("rd_addr", mem_addr, 16'h0100);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cyc();
      if (inst_valid) found = 1'b1;
    end
    chk("rd_found", found, 1);
    chk("rd_pc", pc_ifid, 16'h0100);
    chk("rd_d", inst_ifid, 16'h5B5A);

    // PC wrap at the top of the address space.
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    cyc();
    redirect = 1'b0;
    mem_rdy  = 1'b1;
    auto_rsp = 1'b1;
    #1;
    chk("wr_addr_top", mem_addr, 16'hFFFE);
    cyc();
    chk("wr_addr_wrap", mem_addr, 16'h0000);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      if (inst_valid) found = 1'b1;
      else cyc();
    end
    chk("wr_found", found, 1);
    chk("wr_pc", pc_ifid, 16'hFFFE);

    // Error response on PC 4.
    do_reset();
    mem_rdy    = 1'b1;
    inst_ready = 1'b1;
    auto_rsp   = 1'b1;
    err_on     = 1'b1;
    err_pc     = 16'h0004;
    found = 1'b0;
    e2    = 1'b1;
    e4    = 1'b0;
    for (int k = 0; k < 14; k++) begin
      cyc();
      if (inst_valid && pc_ifid == 16'h0002) e2 = err;
      if (inst_valid && pc_ifid == 16'h0004) begin
        found = 1'b1;
        e4    = err;
      end
    end
`ifdef PF_ERR_HALT_EN
    exp_req = 1'b0;
`else
    exp_req = 1'b1;
`endif
    chk("er_found", found, 1);
    chk("er_err4", e4, 1);
    chk("er_err2", e2, 0);
    chk("er_req_after", mem_req, exp_req);

    // Reset mid-burst with three outstanding.
    do_reset();
    mem_rdy = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    chk("mb_nreq", nreq, 4);
    mem_rvalid = 1'b1;
    mem_rdata  = dat(pend.pop_front());
    cyc();
    mem_rvalid = 1'b0;
    chk("mb_valid", inst_valid, 1);
    rst = 1'b0;
    #1;
    chk("mb_rst_valid", inst_valid, 0);
    chk("mb_rst_req", mem_req, 0);
    chk("mb_rst_ifid", inst_ifid, 0);
    chk("mb_rst_pc", pc_ifid, 0);
    chk("mb_rst_err", err, 0);
    chk("mb_rst_addr", mem_addr, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    cyc();
    mem_rvalid = 1'b0;
    pend.delete();
    nreq       = 0;
    rst        = 1'b1;
    auto_rsp   = 1'b1;
    inst_ready = 1'b1;
    #1;
    chk("mb_post_req", mem_req, 1);
    chk("mb_post_addr", mem_addr, 16'h0000);
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      cyc();
      if (inst_valid) found = 1'b1;
    end
    chk("mb_post_found", found, 1);
    chk("mb_post_pc", pc_ifid, 16'h0000);
    chk("mb_post_d", inst_ifid, 16'h5A5A);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
